// File: rtl/rgb_matrix_pkg.sv
// Shared types and defaults for the LED matrix frame datapath.
// Holds matrix geometry defaults, the writer state type and address sizing.
package rgb_matrix_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_HEIGHT   = 8;
  localparam int DEF_CHANNELS = 3;
  localparam int DEF_COLOR_W  = 8;

  typedef enum logic {
    IDLE,
    WRITE
  } state_e;

  function automatic int addr_w(input int bank_words);
    return $clog2(2 * bank_words);
  endfunction

endpackage

// File: rtl/channel_serializer.sv
// Loads one packed pixel and emits its colour channels one per cycle.
// slice_o is registered; last_o flags the final channel of the pixel.
module channel_serializer #(
  parameter int CHANNELS = 3,
  parameter int COLOR_W  = 8,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_i,
  input  logic                        step_i,
  input  logic [CHANNELS*COLOR_W-1:0] data_i,
  output logic [COLOR_W-1:0]          slice_o,
  output logic [CH_W-1:0]             ch_o,
  output logic                        last_o
);

  logic [CHANNELS*COLOR_W-1:0] data_q;
  logic [CH_W-1:0]             ch_q;
  logic [CH_W-1:0]             ch_d;
  logic [COLOR_W-1:0]          slice_q;

  assign ch_d    = ch_q + CH_W'(1);
  assign slice_o = slice_q;
  assign ch_o    = ch_q;
  assign last_o  = (int'(ch_q) == CHANNELS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      slice_q <= '0;
    end else if (load_i) begin
      data_q  <= data_i;
      ch_q    <= '0;
      slice_q <= data_i[COLOR_W-1:0];
    end else if (step_i) begin
      ch_q    <= ch_d;
      slice_q <= data_q[int'(ch_d)*COLOR_W +: COLOR_W];
    end
  end

endmodule

// File: rtl/rgb_frame_writer.sv
// Pixel stream to ping-pong frame BRAM writer.
// Serialises channels into words and swaps banks on each completed frame.
module rgb_frame_writer
  import rgb_matrix_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HEIGHT   = DEF_HEIGHT,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int COLOR_W  = DEF_COLOR_W,
  localparam int PIXELS     = WIDTH * HEIGHT,
  localparam int BANK_WORDS = PIXELS * CHANNELS,
  localparam int ADDR_W     = addr_w(BANK_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sof,
  input  logic [CHANNELS*COLOR_W-1:0] in_data,
  output logic                        bram_we,
  output logic [ADDR_W-1:0]           bram_addr,
  output logic [COLOR_W-1:0]          bram_data,
  output logic                        disp_bank,
  output logic                        frame_done,
  output logic                        overflow
);

  localparam int CNT_W = $clog2(PIXELS + 1);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_e            state_q;
  logic [CNT_W-1:0]  pix_cnt_q;
  logic [CNT_W-1:0]  pix_idx_q;
  logic              pix_ok_q;
  logic              wr_bank_q;
  logic              disp_bank_q;
  logic              frame_done_q;
  logic              overflow_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;

  logic [CH_W-1:0]   ch;
  logic              last;
  logic              accept;
  logic              step;
  logic              done;
  logic              swap;
  logic [CNT_W-1:0]  idx_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              ok_d;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] addr_d;

  assign in_ready = (state_q == IDLE) || last;
  assign accept   = in_valid && in_ready;
  assign step     = (state_q == WRITE) && !last;
  assign done     = (state_q == WRITE) && last && !accept;

  assign idx_d = in_sof ? '0 : pix_cnt_q;
  assign ok_d  = (idx_d < CNT_W'(PIXELS));
  assign cnt_d = in_sof ? CNT_W'(1)
               : (pix_cnt_q == CNT_W'(PIXELS)) ? pix_cnt_q
               : pix_cnt_q + CNT_W'(1);

  assign base   = wr_bank_q ? ADDR_W'(BANK_WORDS) : '0;
  assign addr_d = base + ADDR_W'(idx_d) * ADDR_W'(CHANNELS);

  // Swap on the edge that issues the last channel of the final pixel.
  assign swap =
    (accept && (CHANNELS == 1) && (idx_d == CNT_W'(PIXELS - 1))) ||
    (step && (int'(ch) + 2 == CHANNELS) &&
     (pix_idx_q == CNT_W'(PIXELS - 1)));

  channel_serializer #(
    .CHANNELS (CHANNELS),
    .COLOR_W  (COLOR_W),
    .CH_W     (CH_W)
  ) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .step_i  (step),
    .data_i  (in_data),
    .slice_o (bram_data),
    .ch_o    (ch),
    .last_o  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pix_cnt_q    <= '0;
      pix_idx_q    <= '0;
      pix_ok_q     <= 1'b0;
      wr_bank_q    <= 1'b0;
      disp_bank_q  <= 1'b1;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
    end else begin
      frame_done_q <= swap;
      if (swap) begin
        wr_bank_q   <= ~wr_bank_q;
        disp_bank_q <= wr_bank_q;
      end
      unique case (1'b1)
        accept: begin
          state_q   <= WRITE;
          pix_cnt_q <= cnt_d;
          pix_idx_q <= idx_d;
          pix_ok_q  <= ok_d;
          we_q      <= ok_d;
          if (ok_d) addr_q <= addr_d;
          if (in_sof) overflow_q <= 1'b0;
          else if (!ok_d) overflow_q <= 1'b1;
        end
        step: begin
          if (pix_ok_q) addr_q <= addr_q + ADDR_W'(1);
        end
        done: begin
          state_q <= IDLE;
          we_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign disp_bank  = disp_bank_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_rgb_frame_writer.sv
// Self-checking bench for rgb_frame_writer: default and 4-channel builds.
module tb_rgb_frame_writer;

  localparam int C  = 3;
  localparam int CW = 8;
  localparam int P  = 128;
  localparam int BW = P * C;
  localparam int AW = 10;

  localparam int C2  = 4;
  localparam int CW2 = 6;
  localparam int P2  = 32;
  localparam int AW2 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            in_valid, in_sof, in_ready;
  logic [C*CW-1:0] in_data;
  logic            bram_we, disp_bank, frame_done, overflow;
  logic [AW-1:0]   bram_addr;
  logic [CW-1:0]   bram_data;

  logic              in_valid2, in_sof2, in_ready2;
  logic [C2*CW2-1:0] in_data2;
  logic              bram_we2, disp_bank2, frame_done2, overflow2;
  logic [AW2-1:0]    bram_addr2;
  logic [CW2-1:0]    bram_data2;

  rgb_frame_writer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_data(in_data),
    .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_data(bram_data), .disp_bank(disp_bank),
    .frame_done(frame_done), .overflow(overflow)
  );

  rgb_frame_writer #(
    .WIDTH(8), .HEIGHT(4), .CHANNELS(C2), .COLOR_W(CW2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_sof(in_sof2), .in_data(in_data2),
    .bram_we(bram_we2), .bram_addr(bram_addr2),
    .bram_data(bram_data2), .disp_bank(disp_bank2),
    .frame_done(frame_done2), .overflow(overflow2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: pixel index rules turned into a queue of writes.
  typedef struct {
    int addr;
    int data;
    bit last;
  } wr_t;

  wr_t q[$];
  bit  m_bank, m_disp, m_ovf;
  int  m_cnt;
  int  fd_seen = 0;

  function automatic void model_reset();
    q.delete();
    m_bank = 1'b0;
    m_disp = 1'b1;
    m_ovf  = 1'b0;
    m_cnt  = 0;
  endfunction

  function automatic void model_accept(input bit sof, input logic [C*CW-1:0] d);
    int  idx;
    wr_t w;
    idx   = sof ? 0 : m_cnt;
    m_cnt = sof ? 1 : ((m_cnt < P) ? m_cnt + 1 : P);
    if (sof) m_ovf = 1'b0;
    if (idx >= P) begin
      m_ovf = 1'b1;
    end else begin
      for (int c = 0; c < C; c++) begin
        w.addr = int'(m_bank) * BW + idx * C + c;
        w.data = int'(d[c*CW +: CW]);
        w.last = (idx == P - 1) && (c == C - 1);
        q.push_back(w);
      end
    end
  endfunction

  bit              s_acc, s_sof;
  logic [C*CW-1:0] s_data;
  wr_t             cur;

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      #2;
      s_acc  = rst_n && in_valid && in_ready;
      s_sof  = in_sof;
      s_data = in_data;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        model_reset();
      end else begin
        if (s_acc) model_accept(s_sof, s_data);
        check("bram_we", int'(bram_we), int'(q.size() != 0));
        if (bram_we && q.size() != 0) begin
          cur = q.pop_front();
          check("bram_addr", int'(bram_addr), cur.addr);
          check("bram_data", int'(bram_data), cur.data);
          if (cur.last) begin
            m_bank = ~m_bank;
            m_disp = ~m_bank;
          end
        end
        check("frame_done", int'(frame_done), int'(bram_we && cur.last));
        check("disp_bank", int'(disp_bank), int'(m_disp));
        check("overflow", int'(overflow), int'(m_ovf));
        cur.last = 1'b0;
        if (frame_done) fd_seen++;
      end
    end
  end

  // Second build: addresses run 0..255 over two back-to-back frames.
  int w2  = 0;
  int fd2 = 0;

  function automatic logic [C2*CW2-1:0] pat2(input int g);
    return (C2*CW2)'(g * 37 + 5);
  endfunction

  initial begin
    logic [C2*CW2-1:0] pv;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && bram_we2) begin
        pv = pat2(w2 / C2);
        check("dut2_addr", int'(bram_addr2), w2);
        check("dut2_data", int'(bram_data2),
              int'(pv[(w2 % C2)*CW2 +: CW2]));
        w2++;
      end
      if (rst_n && frame_done2) fd2++;
    end
  end

  task automatic chk_reset(input string tag);
    check({tag, "_we"}, int'(bram_we), 0);
    check({tag, "_addr"}, int'(bram_addr), 0);
    check({tag, "_data"}, int'(bram_data), 0);
    check({tag, "_disp"}, int'(disp_bank), 1);
    check({tag, "_fd"}, int'(frame_done), 0);
    check({tag, "_ovf"}, int'(overflow), 0);
    check({tag, "_ready"}, int'(in_ready), 1);
  endtask

  task automatic send_px(input bit sof, input logic [C*CW-1:0] d);
    int n;
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    int npix;
    int gap;
    int exp_fd;
    int exp_ovf;
  } sc_t;

  typedef struct {
    bit we;
    int addr;
    int data;
    bit rdy;
  } hv_t;

  sc_t sc[8];
  hv_t hv[4];

  initial begin
    int fd0, n;
    rst_n = 1'b0;
    in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    in_valid2 = 1'b0; in_sof2 = 1'b0; in_data2 = '0;

    sc[0] = '{128, 0, 1, 0};
    sc[1] = '{128, 0, 1, 0};
    sc[2] = '{50, 0, 0, 0};
    sc[3] = '{6, 2, 0, 0};
    sc[4] = '{130, 0, 1, 1};
    sc[5] = '{3, 1, 0, 0};
    sc[6] = '{int'($urandom_range(1, 140)), int'($urandom_range(0, 2)), -1, -1};
    sc[7] = '{int'($urandom_range(1, 140)), int'($urandom_range(0, 2)), -1, -1};

    hv[0] = '{1'b1, 0, 8'hFF, 1'b0};
    hv[1] = '{1'b1, 1, 8'h00, 1'b0};
    hv[2] = '{1'b1, 2, 8'h00, 1'b1};
    hv[3] = '{1'b0, 0, 0, 1'b1};

    repeat (3) @(negedge clk);
    chk_reset("rst");
    check("rst2_we", int'(bram_we2), 0);
    check("rst2_disp", int'(disp_bank2), 1);
    rst_n = 1'b1;

    // First pixel: exact write sequence and in_ready shape.
    in_valid = 1'b1; in_sof = 1'b1; in_data = 24'h0000FF;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("px0_we%0d", i), int'(bram_we), int'(hv[i].we));
      check($sformatf("px0_rdy%0d", i), int'(in_ready), int'(hv[i].rdy));
      if (hv[i].we) begin
        check($sformatf("px0_addr%0d", i), int'(bram_addr), hv[i].addr);
        check($sformatf("px0_data%0d", i), int'(bram_data), hv[i].data);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);

    // Second build: two full frames, data held valid throughout.
    for (int g = 0; g < 2 * P2; g++) begin
      in_valid2 = 1'b1;
      in_sof2   = (g % P2 == 0);
      in_data2  = pat2(g);
      n = 0;
      while (!in_ready2 && n < 20) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
    end
    in_valid2 = 1'b0;
    in_sof2   = 1'b0;
    repeat (8) @(negedge clk);
    check("dut2_writes", w2, 2 * P2 * C2);
    check("dut2_frames", fd2, 2);
    check("dut2_disp", int'(disp_bank2), 1);
    check("dut2_ovf", int'(overflow2), 0);

    for (int s = 0; s < 8; s++) begin
      fd0 = fd_seen;
      for (int p = 0; p < sc[s].npix; p++) begin
        send_px(p == 0, (C*CW)'($urandom()));
        repeat (sc[s].gap) @(negedge clk);
      end
      drain();
      if (sc[s].exp_fd >= 0) begin
        check($sformatf("sc%0d_frames", s), fd_seen - fd0, sc[s].exp_fd);
        check($sformatf("sc%0d_ovf", s), int'(overflow), sc[s].exp_ovf);
      end
    end

    // Reset during the second channel write of a pixel.
    in_valid = 1'b1; in_sof = 1'b1; in_data = (C*CW)'($urandom());
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_px(1'b1, 24'hA5C33C);
    check("postrst_we", int'(bram_we), 1);
    check("postrst_addr", int'(bram_addr), 0);
    check("postrst_data", int'(bram_data), 8'h3C);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rgb_frame_writer.md
# rgb_frame_writer

Parametrised pixel-stream-to-BRAM frame writer for the LED matrix datapath. Accepts one multi-channel pixel per handshake, serialises its colour channels into consecutive BRAM words, and generates addresses inside a double-buffered (ping-pong) frame store. On a completed frame it swaps banks so the scan-out logic always reads a whole frame. It sits between the pixel receive/decode logic and the dual-port frame BRAM.

## Interface
- WIDTH, 16, matrix columns
- HEIGHT, 8, matrix rows
- CHANNELS, 3, colour channels per pixel (channel 0 = LSBs of in_data)
- COLOR_W, 8, bits per channel; also the BRAM data width
- Derived localparams:
  - PIXELS = WIDTH*HEIGHT
  - BANK_WORDS = PIXELS*CHANNELS
  - ADDR_W = $clog2(2*BANK_WORDS); 10 with the defaults
- clk  in  1  fast system clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  pixel present
- in_ready  out  1  pixel is accepted on a clk edge with in_valid & in_ready
- in_sof  in  1  qualifies the pixel as the first of a frame
- in_data  in  CHANNELS*COLOR_W  packed pixel
- bram_we  out  1  write strobe
- bram_addr  out  ADDR_W  write address
- bram_data  out  COLOR_W  write data
- disp_bank  out  1  bank the scan-out side reads
- frame_done  out  1  one-cycle pulse when a bank swap occurs
- overflow  out  1  sticky: pixels received beyond PIXELS

## Operation
- State machine has two states.
  - IDLE: in_ready=1. On accept, latch in_data, set ch=0, go to WRITE.
  - WRITE: bram_we=1, bram_data = latched channel ch, bram_addr = wr_bank*BANK_WORDS + pix_idx*CHANNELS + ch.
    - While ch<CHANNELS-1: ch++ and in_ready=0.
    - When ch==CHANNELS-1: in_ready=1. If a pixel is accepted on that edge, reload and stay in WRITE with ch=0. Otherwise return to IDLE.
- Pixel index:
  - An accepted pixel with in_sof uses index 0.
  - Otherwise the pixel uses pix_cnt, where pix_cnt counts accepted pixels since the last sof.
  - pix_cnt saturates at PIXELS.
- Overflow:
  - A pixel accepted with index ≥ PIXELS is accepted, but no BRAM write is issued (bram_we stays 0 for its CHANNELS cycles).
  - That pixel sets overflow.
  - overflow clears when an in_sof pixel is accepted.
- Frame completion: the final channel write of index PIXELS-1 does three things on that same edge:
  - toggles wr_bank;
  - sets disp_bank to the old wr_bank (so disp_bank = ~wr_bank always);
  - pulses frame_done high for the following cycle.
- Partial frame: an in_sof pixel arriving before index PIXELS-1 completes discards the partial frame. There is no bank swap, and writing restarts at index 0 of the same bank.
- Reset values: state IDLE, in_ready 1, bram_we 0, bram_addr 0, bram_data 0, wr_bank 0, disp_bank 1, frame_done 0, overflow 0, pix_cnt 0. Reset mid-write abandons the pixel immediately; no further writes are issued.

## Timing
- bram_we, bram_addr and bram_data are registered.
- The first write appears in the cycle after acceptance, and the pixel occupies exactly CHANNELS consecutive write cycles.
- Sustained throughput is one pixel per CHANNELS cycles with no idle cycle between pixels.
- in_ready is combinational from state/ch only. It never depends on in_valid.
- disp_bank changes on the same edge as the last write of the frame is issued. The scan-out side samples it at its own frame boundary.
- Address arithmetic is unsigned, ADDR_W bits. The maximum address is 2*BANK_WORDS-1, so there is no wrap.

## Structure
- Shared package rgb_matrix_pkg holds:
  - default WIDTH, HEIGHT, CHANNELS, COLOR_W;
  - the state enum (IDLE, WRITE);
  - a function computing ADDR_W.
- One natural sub-module: channel_serializer. It loads a CHANNELS*COLOR_W word and emits one COLOR_W slice per cycle with a last flag. Address, bank and overflow logic stay in the top.

## Test plan
- Reset, then one sof pixel 0x0000FF/0x00FF00/0xFF0000 with defaults -> writes to addresses 0, 1, 2 with data 0xFF, 0x00, 0x00. in_ready is low for 2 cycles.
- in_valid held high for 128 pixels starting with sof -> 384 back-to-back writes at addresses 0..383. frame_done pulses once. disp_bank goes 1 -> 0. A second frame writes 384..767.
- 50 pixels, then a new sof -> no bank swap, no frame_done. The sof pixel writes addresses 0..2.
- 130 pixels after sof -> pixels 128 and 129 produce no bram_we and overflow=1. The next sof clears overflow.
- rst_n asserted during the second channel write -> outputs return to reset values asynchronously. The next sof pixel writes to address 0.
- CHANNELS=4, COLOR_W=6, WIDTH=8, HEIGHT=4 -> ADDR_W=8. A full frame gives 128 writes, 4 per pixel, and the bank-1 base is 128.
